// File: rtl/toggle_sequencer_if.sv
// Control/observe bundle between bench-side sequencing logic and the toggle sequencer.
// The master side drives the sequence request; the slave side generates the signal.
interface toggle_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 8
);
  logic             start;
  logic             abort;
  logic             init_level;
  logic [PER_W-1:0] period;
  logic [CNT_W-1:0] n_toggles;
  logic             sig;
  logic             sig_q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggles_done;
  logic [CNT_W-1:0] rise_cnt;

  modport master (
    output start, abort, init_level, period, n_toggles,
    input  sig, sig_q, busy, done, toggles_done, rise_cnt
  );

  modport slave (
    input  start, abort, init_level, period, n_toggles,
    output sig, sig_q, busy, done, toggles_done, rise_cnt
  );
endinterface

// File: rtl/toggle_sequencer.sv
// Programmable toggle generator: start level, period, toggle count, with a
// one-cycle delayed copy of the signal and a rising-edge observer.
module toggle_sequencer #(
  parameter int CNT_W = 16,
  parameter int PER_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  toggle_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             lvl_q, lvl_d;
  logic             dly_q;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic             due;
  logic [CNT_W-1:0] tog_inc;

  assign due     = (phase_q == per_q - PER_W'(1));
  assign tog_inc = tog_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    phase_d = phase_q;
    per_d   = per_q;
    n_d     = n_q;
    tog_d   = tog_q;
    rise_d  = rise_q;
    unique case (state_q)
      IDLE: begin
        // start wins over a coincident abort; abort has no meaning here
        if (bus.start) begin
          per_d   = (bus.period == '0) ? PER_W'(1) : bus.period;
          n_d     = bus.n_toggles;
          lvl_d   = bus.init_level;
          tog_d   = '0;
          rise_d  = '0;
          phase_d = '0;
          state_d = (bus.n_toggles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // abort suppresses a toggle that falls due in the same cycle
        if (bus.abort) begin
          state_d = IDLE;
        end else if (due) begin
          lvl_d   = ~lvl_q;
          tog_d   = tog_inc;
          phase_d = '0;
          if (!lvl_q) rise_d = rise_q + CNT_W'(1);
          if (tog_inc == n_q) state_d = DONE;
        end else begin
          phase_d = phase_q + PER_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= 1'b0;
      dly_q   <= 1'b0;
      phase_q <= '0;
      per_q   <= '0;
      n_q     <= '0;
      tog_q   <= '0;
      rise_q  <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dly_q   <= lvl_q;
      phase_q <= phase_d;
      per_q   <= per_d;
      n_q     <= n_d;
      tog_q   <= tog_d;
      rise_q  <= rise_d;
    end
  end

  assign bus.sig          = lvl_q;
  assign bus.sig_q        = dly_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.toggles_done = tog_q;
  assign bus.rise_cnt     = rise_q;

endmodule

// File: tb/tb_toggle_sequencer.sv
// Self-checking bench: table of sequences with a closed-form expected waveform,
// plus hand-written abort and mid-run reset sequences.
module tb_toggle_sequencer;
  localparam int CNT_W = 16;
  localparam int PER_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toggle_sequencer_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();
  toggle_sequencer #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit init;
    int per;
    int n;
    bit abort_w_start;
    bit restart;
  } vec_t;

  typedef struct {
    logic sig, sig_q, busy, done;
    int   tog, rise, c;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  logic last_sig = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs c cycles after the start edge, derived from toggle k at edge T+k*P.
  function automatic exp_t model(input bit init, input int per, input int n, input int c, input logic prev);
    exp_t e;
    int pe, k;
    pe = (per == 0) ? 1 : per;
    k  = c / pe;
    if (k > n) k = n;
    e.sig   = init ^ k[0];
    e.sig_q = prev;
    e.tog   = k;
    e.rise  = init ? k / 2 : (k + 1) / 2;
    e.busy  = (n != 0) && (c < n * pe);
    e.done  = (c == n * pe);
    e.c     = c;
    return e;
  endfunction

  task automatic compare_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s_c%0d_sig", tag, e.c),   {31'd0, bus.sig},   {31'd0, e.sig});
    chk($sformatf("%s_c%0d_sigq", tag, e.c),  {31'd0, bus.sig_q}, {31'd0, e.sig_q});
    chk($sformatf("%s_c%0d_busy", tag, e.c),  {31'd0, bus.busy},  {31'd0, e.busy});
    chk($sformatf("%s_c%0d_done", tag, e.c),  {31'd0, bus.done},  {31'd0, e.done});
    chk($sformatf("%s_c%0d_tog", tag, e.c),   {16'd0, bus.toggles_done}, e.tog);
    chk($sformatf("%s_c%0d_rise", tag, e.c),  {16'd0, bus.rise_cnt},     e.rise);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   pe, last;
    logic prev;
    exp_t e;
    pe   = (v.per == 0) ? 1 : v.per;
    last = pe * v.n;
    prev = last_sig;
    for (int c = 0; c <= last + 2; c++) begin
      if (c == 0) begin
        bus.init_level = v.init;
        bus.period     = PER_W'(v.per);
        bus.n_toggles  = CNT_W'(v.n);
        bus.start      = 1'b1;
        bus.abort      = v.abort_w_start;
      end else if (v.restart && (c == 3 || c == last + 1)) begin
        // competing request with different config while RUN / DONE
        bus.init_level = ~v.init;
        bus.period     = 8'd1;
        bus.n_toggles  = 16'd7;
        bus.start      = 1'b1;
      end
      e = model(v.init, v.per, v.n, c, prev);
      sb.push_back(e);
      prev = e.sig;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      compare_sb(tag);
    end
    last_sig = prev;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic prev;
    bus.start = 1'b0; bus.abort = 1'b0; bus.init_level = 1'b0;
    bus.period = '0; bus.n_toggles = '0;

    vecs.push_back('{init: 1'b0, per: 5, n: 4, abort_w_start: 1'b0, restart: 1'b0});
    vecs.push_back('{init: 1'b1, per: 3, n: 0, abort_w_start: 1'b0, restart: 1'b0});
    vecs.push_back('{init: 1'b1, per: 0, n: 3, abort_w_start: 1'b0, restart: 1'b0});
    vecs.push_back('{init: 1'b0, per: 5, n: 4, abort_w_start: 1'b0, restart: 1'b1});
    vecs.push_back('{init: 1'b0, per: 1, n: 5, abort_w_start: 1'b1, restart: 1'b0});
    vecs.push_back('{init: 1'b1, per: 3, n: 4, abort_w_start: 1'b0, restart: 1'b0});
    vecs.push_back('{init: 1'b0, per: 2, n: 1, abort_w_start: 1'b0, restart: 1'b0});

    #3;
    chk("rst_sig",  {31'd0, bus.sig},   32'd0);
    chk("rst_sigq", {31'd0, bus.sig_q}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy},  32'd0);
    chk("rst_done", {31'd0, bus.done},  32'd0);
    chk("rst_tog",  {16'd0, bus.toggles_done}, 32'd0);
    chk("rst_rise", {16'd0, bus.rise_cnt},     32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort coinciding with toggle 2 (edge T+10)
    prev = last_sig;
    for (int c = 0; c <= 14; c++) begin
      bus.start      = (c == 0);
      bus.abort      = (c == 10);
      bus.init_level = 1'b0;
      bus.period     = 8'd5;
      bus.n_toggles  = 16'd4;
      e = model(1'b0, 5, 4, c, prev);
      if (c >= 10) begin
        e.sig = 1'b1; e.tog = 1; e.rise = 1; e.busy = 1'b0; e.done = 1'b0;
      end
      sb.push_back(e);
      prev = e.sig;
      tick();
      compare_sb("abort");
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    last_sig = prev;

    // asynchronous reset between edges T+11 and T+12
    prev = last_sig;
    for (int c = 0; c <= 11; c++) begin
      bus.start      = (c == 0);
      bus.init_level = 1'b0;
      bus.period     = 8'd5;
      bus.n_toggles  = 16'd4;
      e = model(1'b0, 5, 4, c, prev);
      sb.push_back(e);
      prev = e.sig;
      tick();
      compare_sb("prerst");
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sig",  {31'd0, bus.sig},   32'd0);
    chk("arst_sigq", {31'd0, bus.sig_q}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy},  32'd0);
    chk("arst_tog",  {16'd0, bus.toggles_done}, 32'd0);
    chk("arst_rise", {16'd0, bus.rise_cnt},     32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    last_sig = 1'b0;
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    run_vec('{init: 1'b0, per: 2, n: 2, abort_w_start: 1'b0, restart: 1'b0}, "postrst");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/toggle_sequencer.md
Name: toggle_sequencer

Overview:
- Drives one test signal `sig` with a programmable toggle pattern: a start level, a fixed period in clock cycles, and a toggle count.
- Keeps a one-cycle registered copy of `sig` so benches can compare blocking-style and nonblocking-style views of the same value.
- Counts rising edges of `sig` as a built-in observer.
- Sits between bench control logic and the signal-under-test; benches sequence it with a start/busy/done handshake.

Parameters:
- CNT_W, 16, width of toggle count and of the toggle/edge counters.
- PER_W, 8, width of the period field.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- abort  in  1  stop a running sequence.
- init_level  in  1  level driven on `sig` when start is accepted.
- period  in  PER_W  cycles between toggles; 0 is treated as 1.
- n_toggles  in  CNT_W  number of toggles to perform.
- sig  out  1  generated signal.
- sig_q  out  1  `sig` delayed one clock.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at normal sequence completion.
- toggles_done  out  CNT_W  toggles performed in the current or last sequence.
- rise_cnt  out  CNT_W  0->1 transitions of `sig` in the current or last sequence.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - sig=0, sig_q=0, busy=0, done=0, toggles_done=0, rise_cnt=0.
  - Internal phase counter and latched config cleared.
- States are IDLE, RUN and DONE.
- IDLE, start=1 at edge T:
  - Latch P=max(period,1) and N=n_toggles.
  - sig<=init_level; toggles_done<=0; rise_cnt<=0; phase<=0.
  - If N==0, go to DONE; otherwise go to RUN with busy<=1.
- RUN:
  - phase increments each cycle.
  - When phase==P-1: sig<=~sig, toggles_done+=1, phase<=0.
  - rise_cnt+=1 when that toggle takes sig from 0 to 1.
  - Toggle k occurs at edge T+k*P.
  - At the toggle that makes toggles_done==N (edge T+N*P): go to DONE, busy<=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- sig holds its last level in IDLE and DONE; it never returns to 0 except on reset.
- sig_q <= sig on every edge in every state.
- start while in RUN or DONE is ignored: no relatch, no counter clear.
- abort in RUN:
  - Next state is IDLE, busy<=0, done stays 0.
  - sig, toggles_done and rise_cnt hold.
  - abort and a due toggle in the same cycle: abort wins and the toggle is suppressed.
- abort in IDLE or DONE has no effect. start and abort together in IDLE: start is accepted.
- Counters cannot wrap because toggles_done ≤ N ≤ 2^CNT_W-1.
- rst_n deasserting mid-run clears everything immediately. After release the block waits in IDLE for a new start.

Test Plan:
1. init_level=0, period=5, n_toggles=4, start at edge T:
   - sig=0 at T; 1 at T+5; 0 at T+10; 1 at T+15; 0 at T+20.
   - busy high T..T+20, done pulse in the cycle after edge T+20.
   - rise_cnt=2, toggles_done=4.
   - sig_q always equals sig from the previous cycle.
2. n_toggles=0, init_level=1: sig=1 after T, busy never high, done pulses in the cycle after T, counters 0.
3. period=0, init_level=1, n_toggles=3:
   - sig toggles every cycle: 0 at T+1, 1 at T+2, 0 at T+3.
   - rise_cnt=1, done after edge T+3.
4. period=5, n_toggles=4, abort at edge T+10 (coincides with toggle 2):
   - Toggle suppressed, sig stays 1, toggles_done=1, rise_cnt=1.
   - busy low, done never asserted.
5. Second start pulsed at T+3 during test 1: ignored, identical waveform to test 1.
6. rst_n driven low asynchronously at T+12 during test 1:
   - sig, sig_q, busy, counters read 0 before the next clock edge.
   - After release and a fresh start with period=2, n_toggles=2, init_level=0: toggles occur at T'+2 and T'+4.
